// File: rtl/tw_defs.sv
// Shared definitions for the threewire master arbiter: FSM state encoding,
// requester indices and the data pattern returned on a watchdog timeout.
package tw_defs;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } tw_state_t;

    localparam int TW_REQ_HOST = 0;
    localparam int TW_REQ_POLL = 1;

    // Wide enough for any supported DATA_BITS; users slice the low bits.
    localparam logic [63:0] TW_TIMEOUT_DATA = '1;

endpackage

// File: rtl/tw_rr_picker.sv
// Combinational 2-way round-robin selector: the prio holder wins when it
// requests, otherwise the other requester wins. Output is one-hot or zero.
module tw_rr_picker (
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] win
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            assign win[gi] = req[gi] && ((prio == 1'(gi)) || !req[1 - gi]);
        end
    endgenerate

endmodule

// File: rtl/tw_master_arbiter.sv
// Shares one threewire master between the host parser and the register
// poller: round-robin grant, one transaction per grant, watchdog on completion.
module tw_master_arbiter
    import tw_defs::*;
#(
    parameter int ADDRESS_BITS   = 16,
    parameter int DATA_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      in_clk,
    input  logic                      in_reset,
    input  logic [1:0]                in_req,
    input  logic [1:0]                in_wr,
    input  logic [2*ADDRESS_BITS-1:0] in_addr,
    input  logic [2*DATA_BITS-1:0]    in_wdata,
    output logic [1:0]                out_gnt,
    output logic [1:0]                out_done,
    output logic                      out_timeout,
    output logic [DATA_BITS-1:0]      out_rdata,
    output logic                      out_tw_start,
    output logic                      out_tw_wr,
    output logic [ADDRESS_BITS-1:0]   out_tw_addr,
    output logic [DATA_BITS-1:0]      out_tw_wdata,
    input  logic                      in_tw_busy,
    input  logic                      in_tw_done,
    input  logic [DATA_BITS-1:0]      in_tw_rdata
);

    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES - 1);

    tw_state_t state_reg, state_next;

    logic                    prio_reg;
    logic [1:0]              gnt_reg;
    logic [1:0]              done_reg;
    logic                    timeout_reg;
    logic [DATA_BITS-1:0]    rdata_reg;
    logic                    start_reg;
    logic                    tw_wr_reg;
    logic [ADDRESS_BITS-1:0] tw_addr_reg;
    logic [DATA_BITS-1:0]    tw_wdata_reg;
    logic [WD_BITS-1:0]      wd_reg;

    logic [1:0]              win;
    logic                    win_idx;
    logic                    arb_go;
    logic                    wd_expired;
    logic [ADDRESS_BITS-1:0] req_addr  [2];
    logic [DATA_BITS-1:0]    req_wdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_addr[gi]  = in_addr[gi*ADDRESS_BITS +: ADDRESS_BITS];
            assign req_wdata[gi] = in_wdata[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    tw_rr_picker u_picker (
        .req  (in_req),
        .prio (prio_reg),
        .win  (win)
    );

    assign win_idx    = win[TW_REQ_POLL];
    assign wd_expired = (wd_reg == WD_LIMIT);
    // Arbitration is held off while out_done is pulsing so the finished
    // requester gets one cycle to drop or change its request.
    assign arb_go     = (|in_req) && !in_tw_busy && !(|done_reg);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:     if (arb_go) state_next = ST_ISSUE;
            ST_ISSUE:    state_next = ST_WAIT;
            ST_WAIT:     if (in_tw_done || wd_expired) state_next = ST_COMPLETE;
            ST_COMPLETE: state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_reg    <= ST_IDLE;
            prio_reg     <= 1'(TW_REQ_HOST);
            gnt_reg      <= '0;
            done_reg     <= '0;
            timeout_reg  <= 1'b0;
            rdata_reg    <= '0;
            start_reg    <= 1'b0;
            tw_wr_reg    <= 1'b0;
            tw_addr_reg  <= '0;
            tw_wdata_reg <= '0;
            wd_reg       <= '0;
        end else begin
            state_reg <= state_next;
            start_reg <= 1'b0;
            done_reg  <= '0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (arb_go) begin
                        gnt_reg      <= win;
                        tw_wr_reg    <= in_wr[win_idx];
                        tw_addr_reg  <= req_addr[win_idx];
                        tw_wdata_reg <= req_wdata[win_idx];
                    end
                end
                ST_ISSUE: begin
                    start_reg <= 1'b1;
                    wd_reg    <= '0;
                end
                ST_WAIT: begin
                    if (in_tw_done) begin
                        if (!tw_wr_reg) rdata_reg <= in_tw_rdata;
                        timeout_reg <= 1'b0;
                    end else if (wd_expired) begin
                        timeout_reg <= 1'b1;
                        rdata_reg   <= TW_TIMEOUT_DATA[DATA_BITS-1:0];
                    end else if (wd_reg != '1) begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_COMPLETE: begin
                    done_reg <= gnt_reg;
                    gnt_reg  <= '0;
                    // Priority passes to whoever did not just win.
                    prio_reg <= gnt_reg[TW_REQ_HOST];
                end
                default: ;
            endcase
        end
    end

    assign out_gnt      = gnt_reg;
    assign out_done     = done_reg;
    assign out_timeout  = timeout_reg;
    assign out_rdata    = rdata_reg;
    assign out_tw_start = start_reg;
    assign out_tw_wr    = tw_wr_reg;
    assign out_tw_addr  = tw_addr_reg;
    assign out_tw_wdata = tw_wdata_reg;

endmodule

// File: tb/tb_tw_master_arbiter.sv
// Randomised self-checking bench for tw_master_arbiter with a behavioural
// threewire slave and a round-robin/readback reference model.
module tb_tw_master_arbiter;

    localparam int AB = 16;
    localparam int DB = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [2*AB-1:0] addr;
    logic [2*DB-1:0] wdata;
    logic [1:0]    out_gnt;
    logic [1:0]    out_done;
    logic          out_timeout;
    logic [DB-1:0] out_rdata;
    logic          out_tw_start;
    logic          out_tw_wr;
    logic [AB-1:0] out_tw_addr;
    logic [DB-1:0] out_tw_wdata;
    logic          tw_busy;
    logic          tw_done;
    logic [DB-1:0] tw_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // slave model state
    int slave_lat = 1;
    int cd = 0;
    int start_count = 0;
    int done_drive_cyc = 0;
    logic [DB-1:0] slave_rdata = '0;

    // reference model state
    logic [DB-1:0] model_rdata = '0;
    int model_prio = 0;

    tw_master_arbiter #(
        .ADDRESS_BITS   (AB),
        .DATA_BITS      (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .in_clk       (clk),
        .in_reset     (rst),
        .in_req       (req),
        .in_wr        (wr),
        .in_addr      (addr),
        .in_wdata     (wdata),
        .out_gnt      (out_gnt),
        .out_done     (out_done),
        .out_timeout  (out_timeout),
        .out_rdata    (out_rdata),
        .out_tw_start (out_tw_start),
        .out_tw_wr    (out_tw_wr),
        .out_tw_addr  (out_tw_addr),
        .out_tw_wdata (out_tw_wdata),
        .in_tw_busy   (tw_busy),
        .in_tw_done   (tw_done),
        .in_tw_rdata  (tw_rdata)
    );

    always #5 clk = ~clk;

    // One clock: sample on the falling edge, then let the slave react.
    // slave_lat == 0 models a slave that never answers.
    task automatic tick();
        @(negedge clk);
        cyc++;
        tw_done = 1'b0;
        if (out_tw_start) begin
            start_count++;
            cd = slave_lat;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                tw_done = 1'b1;
                tw_rdata = slave_rdata;
                done_drive_cyc = cyc;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (out_done != 2'b00) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; tw_done = 1'b0; tw_busy = 1'b0; cd = 0;
        tick(); tick();
        rst = 1'b0;
        model_prio = 0;
        model_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; wr = '0; addr = '0; wdata = '0;
        tw_busy = 1'b0; tw_done = 1'b0; tw_rdata = '0; cd = 0;
        tick(); tick();
        checks++; if (out_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", out_gnt); end
        checks++; if (out_done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", out_done); end
        checks++; if (out_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", out_timeout); end
        checks++; if (out_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", out_rdata); end
        checks++; if ({out_tw_start, out_tw_wr} !== 2'b00 || out_tw_addr !== '0 || out_tw_wdata !== '0) begin
            errors++; $display("FAIL reset_tw_cmd: got start=%b wr=%b addr=%h wdata=%h expected all 0",
                                out_tw_start, out_tw_wr, out_tw_addr, out_tw_wdata);
        end
        rst = 1'b0;
        model_prio = 0;
        model_rdata = '0;
        $display("txn reset: outputs checked");
    endtask

    task automatic test_single_read();
        bit seen;
        wr[0] = 1'b0; addr[0 +: AB] = 16'h01AA; wdata[0 +: DB] = $urandom;
        slave_rdata = 32'hAABBCCDD; slave_lat = 3; start_count = 0;
        req[0] = 1'b1;
        tick();
        checks++; if (out_gnt !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", out_gnt); end
        tick();
        checks++; if (out_tw_start !== 1'b1 || out_tw_wr !== 1'b0 || out_tw_addr !== 16'h01AA) begin
            errors++; $display("FAIL single_cmd: got start=%b wr=%b addr=%h expected 1 0 01aa", out_tw_start, out_tw_wr, out_tw_addr);
        end
        wait_done(40, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL single_done_wait: got no out_done expected one within 40 clocks");
        end else begin
            checks++; if (out_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b expected 01", out_done); end
            checks++; if (out_rdata !== 32'hAABBCCDD) begin errors++; $display("FAIL single_rdata: got %h expected aabbccdd", out_rdata); end
            checks++; if (out_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b expected 0", out_timeout); end
            checks++; if (cyc != done_drive_cyc + 2) begin errors++; $display("FAIL single_latency: got %0d expected %0d", cyc - done_drive_cyc, 2); end
            checks++; if (start_count != 1) begin errors++; $display("FAIL single_starts: got %0d expected 1", start_count); end
            checks++; if (out_gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_drop: got %b expected 00", out_gnt); end
        end
        req[0] = 1'b0;
        model_rdata = 32'hAABBCCDD;
        model_prio = 1;
        $display("txn single_read: req=0 addr=01aa rdata=%h", out_rdata);
        tick();
    endtask

    task automatic test_poll_write();
        bit seen;
        wr[1] = 1'b1; addr[AB +: AB] = 16'h0055; wdata[DB +: DB] = 32'hEFBEADDE;
        slave_rdata = $urandom; slave_lat = $urandom_range(1, 5);
        req[1] = 1'b1;
        tick();
        checks++; if (out_gnt !== 2'b10) begin errors++; $display("FAIL write_gnt: got %b expected 10", out_gnt); end
        tick();
        checks++; if (out_tw_start !== 1'b1 || out_tw_wr !== 1'b1 || out_tw_addr !== 16'h0055 || out_tw_wdata !== 32'hEFBEADDE) begin
            errors++; $display("FAIL write_cmd: got start=%b wr=%b addr=%h wdata=%h expected 1 1 0055 efbeadde",
                                out_tw_start, out_tw_wr, out_tw_addr, out_tw_wdata);
        end
        wait_done(40, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL write_done_wait: got no out_done expected one within 40 clocks");
        end else begin
            checks++; if (out_done !== 2'b10) begin errors++; $display("FAIL write_done: got %b expected 10", out_done); end
            checks++; if (out_rdata !== model_rdata) begin errors++; $display("FAIL write_rdata_kept: got %h expected %h", out_rdata, model_rdata); end
        end
        req[1] = 1'b0;
        model_prio = 0;
        $display("txn poll_write: req=1 addr=0055 wdata=efbeadde rdata=%h", out_rdata);
        tick();
    endtask

    task automatic test_random();
        bit seen;
        logic [1:0] rq;
        int w;
        for (int n = 0; n < 12; n++) begin
            rq = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                wr[i] = 1'($urandom);
                addr[i*AB +: AB] = AB'($urandom);
                wdata[i*DB +: DB] = $urandom;
            end
            slave_rdata = $urandom;
            slave_lat = $urandom_range(1, 6);
            w = rq[model_prio] ? model_prio : 1 - model_prio;
            req = rq;
            tick();
            checks++; if (out_gnt !== 2'(1 << w)) begin errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", n, out_gnt, 2'(1 << w)); end
            tick();
            checks++; if (out_tw_start !== 1'b1 || out_tw_wr !== wr[w] || out_tw_addr !== addr[w*AB +: AB] || out_tw_wdata !== wdata[w*DB +: DB]) begin
                errors++; $display("FAIL rand_cmd[%0d]: got start=%b wr=%b addr=%h wdata=%h expected 1 %b %h %h", n,
                                    out_tw_start, out_tw_wr, out_tw_addr, out_tw_wdata, wr[w], addr[w*AB +: AB], wdata[w*DB +: DB]);
            end
            if (!wr[w]) model_rdata = slave_rdata;
            model_prio = 1 - w;
            wait_done(40, seen);
            checks++;
            if (!seen) begin
                errors++; $display("FAIL rand_done_wait[%0d]: got no out_done expected one within 40 clocks", n);
            end else begin
                checks++; if (out_done !== 2'(1 << w) || out_timeout !== 1'b0 || out_rdata !== model_rdata) begin
                    errors++; $display("FAIL rand_result[%0d]: got done=%b to=%b rdata=%h expected %b 0 %h", n,
                                        out_done, out_timeout, out_rdata, 2'(1 << w), model_rdata);
                end
            end
            $display("txn rand %0d: req=%b winner=%0d wr=%b rdata=%h", n, rq, w, wr[w], out_rdata);
            req = '0;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        logic [1:0] prev_gnt;
        int last_done;
        int n_done;
        int w;
        do_reset();
        wr = '0; addr = {16'h2222, 16'h1111};
        slave_rdata = $urandom; slave_lat = $urandom_range(1, 4);
        prev_gnt = '0; last_done = 0; n_done = 0;
        req = 2'b11;
        for (int i = 0; i < 300 && n_done < 4; i++) begin
            tick();
            checks++; if (out_gnt === 2'b11) begin errors++; $display("FAIL b2b_overlap: got %b expected one-hot", out_gnt); end
            if (prev_gnt == 2'b00 && out_gnt != 2'b00) begin
                order.push_back(int'(out_gnt[1]));
                if (n_done > 0) begin
                    checks++; if (cyc != last_done + 2) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", cyc - last_done - 1, 1); end
                end
            end
            if (out_done != 2'b00) begin
                n_done++;
                last_done = cyc;
                $display("txn b2b %0d: done=%b rdata=%h", n_done, out_done, out_rdata);
            end
            prev_gnt = out_gnt;
        end
        req = '0;
        checks++; if (n_done != 4 || order.size() != 4) begin
            errors++; $display("FAIL b2b_count: got %0d dones %0d grants expected 4 4", n_done, order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                w = model_prio;   // both always request, so the prio holder always wins
                checks++; if (order[k] != w) begin errors++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", k, order[k], w); end
                model_prio = 1 - w;
            end
            model_rdata = slave_rdata;
        end
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int s;
        wr[0] = 1'b0; addr[0 +: AB] = AB'($urandom);
        slave_lat = 0;
        req[0] = 1'b1;
        tick(); tick();
        s = cyc;
        checks++; if (out_tw_start !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", out_tw_start); end
        wait_done(60, seen);
        checks++;
        if (!seen) begin
            errors++; $display("FAIL to_done_wait: got no out_done expected one within 60 clocks");
        end else begin
            checks++; if (cyc != s + TO + 1) begin errors++; $display("FAIL to_latency: got %0d expected %0d", cyc - s, TO + 1); end
            checks++; if (out_done !== 2'b01 || out_timeout !== 1'b1 || out_rdata !== 32'hFFFFFFFF) begin
                errors++; $display("FAIL to_result: got done=%b to=%b rdata=%h expected 01 1 ffffffff", out_done, out_timeout, out_rdata);
            end
        end
        req[0] = 1'b0;
        model_rdata = '1;
        model_prio = 1;
        $display("txn timeout: start@%0d done@%0d rdata=%h", s, cyc, out_rdata);
        tw_done = 1'b1; tw_rdata = $urandom;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_done !== 2'b00 || out_gnt !== 2'b00 || out_tw_start !== 1'b0 || out_rdata !== model_rdata || out_timeout !== 1'b1) begin
                errors++; $display("FAIL late_done[%0d]: got done=%b gnt=%b start=%b rdata=%h to=%b expected 00 00 0 %h 1",
                                    i, out_done, out_gnt, out_tw_start, out_rdata, out_timeout, model_rdata);
            end
        end
    endtask

    task automatic test_busy();
        bit seen;
        wr[0] = 1'b0; addr[0 +: AB] = AB'($urandom);
        slave_rdata = $urandom; slave_lat = 2;
        tw_busy = 1'b1;
        req[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_gnt !== 2'b00) begin errors++; $display("FAIL busy_hold[%0d]: got %b expected 00", i, out_gnt); end
        end
        tw_busy = 1'b0;
        tick();
        checks++; if (out_gnt !== 2'b01) begin errors++; $display("FAIL busy_release_gnt: got %b expected 01", out_gnt); end
        wait_done(40, seen);
        model_rdata = slave_rdata;
        model_prio = 1;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL busy_done_wait: got no out_done expected one within 40 clocks");
        end else begin
            checks++; if (out_done !== 2'b01 || out_rdata !== model_rdata) begin
                errors++; $display("FAIL busy_result: got done=%b rdata=%h expected 01 %h", out_done, out_rdata, model_rdata);
            end
        end
        req[0] = 1'b0;
        $display("txn busy: req=0 rdata=%h", out_rdata);
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        wr[1] = 1'b0; addr[AB +: AB] = AB'($urandom);
        slave_lat = 0;
        req[1] = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        rst = 1'b1; req = '0; cd = 0;
        tick();
        checks++; if (out_gnt !== 2'b00 || out_done !== 2'b00 || out_timeout !== 1'b0 || out_rdata !== '0) begin
            errors++; $display("FAIL midrst_status: got gnt=%b done=%b to=%b rdata=%h expected 00 00 0 0",
                                out_gnt, out_done, out_timeout, out_rdata);
        end
        checks++; if (out_tw_start !== 1'b0 || out_tw_wr !== 1'b0 || out_tw_addr !== '0 || out_tw_wdata !== '0) begin
            errors++; $display("FAIL midrst_cmd: got start=%b wr=%b addr=%h wdata=%h expected all 0",
                                out_tw_start, out_tw_wr, out_tw_addr, out_tw_wdata);
        end
        rst = 1'b0;
        model_prio = 0;
        model_rdata = '0;
        wr = '0; addr = {AB'($urandom), AB'($urandom)};
        slave_rdata = $urandom; slave_lat = 3;
        req = 2'b11;
        tick();
        checks++; if (out_gnt !== 2'b01) begin errors++; $display("FAIL midrst_prio: got %b expected 01", out_gnt); end
        wait_done(40, seen);
        model_rdata = slave_rdata;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL midrst_done_wait: got no out_done expected one within 40 clocks");
        end else begin
            checks++; if (out_done !== 2'b01 || out_rdata !== model_rdata || out_timeout !== 1'b0) begin
                errors++; $display("FAIL midrst_result: got done=%b rdata=%h to=%b expected 01 %h 0",
                                    out_done, out_rdata, out_timeout, model_rdata);
            end
        end
        req = '0;
        $display("txn reset_mid: fresh rdata=%h", out_rdata);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_poll_write();
        test_random();
        test_back_to_back();
        test_timeout();
        test_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
